// File: rtl/ysyx_220066_csr_unit.sv
// ysyx_220066_csr_unit: machine-mode CSR file and trap controller.
// Supplies combinational CSR read data and redirects fetch on trap entry / mret.
module ysyx_220066_csr_unit #(
  parameter int unsigned     XLEN          = 64,
  parameter bit              HAS_COUNTERS  = 1'b1,
  parameter bit              VECTORED_EN   = 1'b1,
  parameter logic [XLEN-1:0] RESET_MSTATUS = XLEN'(64'ha0001800)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [11:0]     csr_rd_addr,
  output logic [XLEN-1:0] csr_rd_data,
  output logic            csr_rd_err,
  input  logic            csr_wen,
  input  logic [11:0]     csr_wr_addr,
  input  logic [XLEN-1:0] csr_wr_data,
  output logic            csr_wr_err,
  input  logic            exc_valid,
  input  logic [XLEN-1:0] exc_cause,
  input  logic [XLEN-1:0] exc_tval,
  input  logic [XLEN-1:0] pc,
  input  logic            boundary,
  input  logic            instret,
  input  logic            mret,
  input  logic            irq_mti,
  input  logic            irq_msi,
  input  logic            irq_mei,
  output logic            intr_take,
  output logic            jmp,
  output logic [XLEN-1:0] nxtpc
);

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MISA     = 12'h301;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MTVAL    = 12'h343;
  localparam logic [11:0] A_MIP      = 12'h344;
  localparam logic [11:0] A_MCYCLE   = 12'hB00;
  localparam logic [11:0] A_MINSTRET = 12'hB02;
  localparam logic [11:0] A_MHARTID  = 12'hF14;

  // MXL=2 in the top two bits, I (bit 8) and M (bit 12) extensions.
  localparam logic [XLEN-1:0] MISA_VAL = {2'b10, {(XLEN-2){1'b0}}} | XLEN'(16'h1100);
  localparam logic [XLEN-1:0] LOW2     = XLEN'(3);

  logic [XLEN-1:0] mstatus_q, mstatus_d;
  logic [XLEN-1:0] mie_q, mie_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [XLEN-1:0] mtval_q, mtval_d;
  logic [XLEN-1:0] mcycle_q, mcycle_d;
  logic [XLEN-1:0] minstret_q, minstret_d;

  logic [XLEN-1:0] mip;
  logic [XLEN-1:0] pend;
  logic [3:0]      intr_code;
  logic            intr_pend;
  logic            trap;
  logic            wr_ok;
  logic            wr_fire;
  logic [XLEN-1:0] mtvec_base;
  logic [XLEN-1:0] trap_cause;

  // Live interrupt lines mapped into mip and the highest-priority enabled source.
  always_comb begin
    mip       = '0;
    mip[7]    = irq_mti;
    mip[3]    = irq_msi;
    mip[11]   = irq_mei;
    pend      = mip & mie_q;
    intr_code = 4'd0;
    if (pend[11])     intr_code = 4'd11;
    else if (pend[3]) intr_code = 4'd3;
    else if (pend[7]) intr_code = 4'd7;
  end

  assign intr_pend  = mstatus_q[3] & (|pend);
  assign intr_take  = boundary & intr_pend & ~exc_valid;
  assign trap       = exc_valid | intr_take;
  assign jmp        = trap | mret;
  assign mtvec_base = mtvec_q & ~LOW2;
  assign trap_cause = exc_valid ? exc_cause : {1'b1, {(XLEN-5){1'b0}}, intr_code};

  // Redirect target: vectored offset only applies to interrupts.
  always_comb begin
    nxtpc = mepc_q;
    if (trap) begin
      nxtpc = mtvec_base;
      if (intr_take && VECTORED_EN && mtvec_q[0]) begin
        nxtpc = mtvec_base + (XLEN'(intr_code) << 2);
      end
    end
  end

  // Combinational read mux; returns the pre-update register values.
  always_comb begin
    csr_rd_data = '0;
    csr_rd_err  = 1'b0;
    case (csr_rd_addr)
      A_MSTATUS:  csr_rd_data = mstatus_q;
      A_MISA:     csr_rd_data = MISA_VAL;
      A_MIE:      csr_rd_data = mie_q;
      A_MTVEC:    csr_rd_data = mtvec_q;
      A_MSCRATCH: csr_rd_data = mscratch_q;
      A_MEPC:     csr_rd_data = mepc_q;
      A_MCAUSE:   csr_rd_data = mcause_q;
      A_MTVAL:    csr_rd_data = mtval_q;
      A_MIP:      csr_rd_data = mip;
      A_MCYCLE:   csr_rd_data = mcycle_q;
      A_MINSTRET: csr_rd_data = minstret_q;
      A_MHARTID:  csr_rd_data = '0;
      default:    csr_rd_err  = 1'b1;
    endcase
  end

  // Writable-address decode; read-only and unmapped addresses flag an error.
  always_comb begin
    wr_ok = 1'b0;
    case (csr_wr_addr)
      A_MSTATUS, A_MIE, A_MTVEC, A_MSCRATCH,
      A_MEPC, A_MCAUSE, A_MTVAL: wr_ok = 1'b1;
      A_MCYCLE, A_MINSTRET:      wr_ok = HAS_COUNTERS;
      default:                   wr_ok = 1'b0;
    endcase
  end

  assign csr_wr_err = csr_wen & ~wr_ok;
  assign wr_fire    = csr_wen & wr_ok & ~trap & ~mret;

  // Next-state: counters tick first, then trap > mret > CSR write overrides.
  always_comb begin
    mstatus_d  = mstatus_q;
    mie_d      = mie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    mcycle_d   = '0;
    minstret_d = '0;
    if (HAS_COUNTERS) begin
      mcycle_d   = mcycle_q + XLEN'(1);
      minstret_d = instret ? minstret_q + XLEN'(1) : minstret_q;
    end
    if (trap) begin
      mepc_d          = pc & ~LOW2;
      mcause_d        = trap_cause;
      mtval_d         = exc_valid ? exc_tval : '0;
      mstatus_d[7]    = mstatus_q[3];
      mstatus_d[3]    = 1'b0;
      mstatus_d[12:11] = 2'b11;
    end else if (mret) begin
      mstatus_d[3]    = mstatus_q[7];
      mstatus_d[7]    = 1'b1;
      mstatus_d[12:11] = 2'b00;
    end else if (wr_fire) begin
      case (csr_wr_addr)
        A_MSTATUS:  mstatus_d  = csr_wr_data;
        A_MIE:      mie_d      = csr_wr_data;
        A_MTVEC:    mtvec_d    = csr_wr_data & (VECTORED_EN ? ~XLEN'(2) : ~LOW2);
        A_MSCRATCH: mscratch_d = csr_wr_data;
        A_MEPC:     mepc_d     = csr_wr_data & ~LOW2;
        A_MCAUSE:   mcause_d   = csr_wr_data;
        A_MTVAL:    mtval_d    = csr_wr_data;
        A_MCYCLE:   mcycle_d   = csr_wr_data;
        A_MINSTRET: minstret_d = csr_wr_data;
        default:    ;
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus_q  <= RESET_MSTATUS;
      mie_q      <= '0;
      mtvec_q    <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      mstatus_q  <= mstatus_d;
      mie_q      <= mie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end

endmodule

// File: tb/tb_ysyx_220066_csr_unit.sv
// Self-checking bench for ysyx_220066_csr_unit with a behavioural CSR model.
module tb_ysyx_220066_csr_unit;

  logic        clk;
  logic        rst;
  logic [11:0] csr_rd_addr;
  logic [63:0] csr_rd_data;
  logic        csr_rd_err;
  logic        csr_wen;
  logic [11:0] csr_wr_addr;
  logic [63:0] csr_wr_data;
  logic        csr_wr_err;
  logic        exc_valid;
  logic [63:0] exc_cause;
  logic [63:0] exc_tval;
  logic [63:0] pc;
  logic        boundary;
  logic        instret;
  logic        mret;
  logic        irq_mti, irq_msi, irq_mei;
  logic        intr_take;
  logic        jmp;
  logic [63:0] nxtpc;

  int checks = 0;
  int errors = 0;

  ysyx_220066_csr_unit #(
    .XLEN(64), .HAS_COUNTERS(1'b1), .VECTORED_EN(1'b1), .RESET_MSTATUS(64'ha0001800)
  ) dut (
    .clk(clk), .rst(rst),
    .csr_rd_addr(csr_rd_addr), .csr_rd_data(csr_rd_data), .csr_rd_err(csr_rd_err),
    .csr_wen(csr_wen), .csr_wr_addr(csr_wr_addr), .csr_wr_data(csr_wr_data),
    .csr_wr_err(csr_wr_err),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_tval(exc_tval), .pc(pc),
    .boundary(boundary), .instret(instret), .mret(mret),
    .irq_mti(irq_mti), .irq_msi(irq_msi), .irq_mei(irq_mei),
    .intr_take(intr_take), .jmp(jmp), .nxtpc(nxtpc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Architectural model state
  logic [63:0] m_mstatus, m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
  logic [63:0] m_mcycle, m_minstret;

  function automatic logic [63:0] m_mip();
    logic [63:0] v = '0;
    v[7] = irq_mti; v[3] = irq_msi; v[11] = irq_mei;
    return v;
  endfunction

  function automatic bit m_writable(input logic [11:0] a);
    return a inside {12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                     12'hB00, 12'hB02};
  endfunction

  // Highest-priority enabled pending source, -1 when none.
  function automatic int m_code();
    int prio[3] = '{11, 3, 7};
    logic [63:0] p = m_mip() & m_mie;
    for (int i = 0; i < 3; i++) if (p[prio[i]]) return prio[i];
    return -1;
  endfunction

  function automatic bit m_take();
    return boundary && m_mstatus[3] && (m_code() >= 0) && !exc_valid;
  endfunction

  function automatic logic [63:0] m_target();
    logic [63:0] t;
    if (exc_valid || m_take()) begin
      t = m_mtvec & ~64'd3;
      if (m_take() && m_mtvec[0]) t = t + 64'(4 * m_code());
    end else t = m_mepc;
    return t;
  endfunction

  function automatic void m_read(input logic [11:0] a, output logic [63:0] d, output bit e);
    e = 1'b0;
    case (a)
      12'h300: d = m_mstatus;
      12'h301: d = 64'h8000_0000_0000_1100;
      12'h304: d = m_mie;
      12'h305: d = m_mtvec;
      12'h340: d = m_mscratch;
      12'h341: d = m_mepc;
      12'h342: d = m_mcause;
      12'h343: d = m_mtval;
      12'h344: d = m_mip();
      12'hB00: d = m_mcycle;
      12'hB02: d = m_minstret;
      12'hF14: d = '0;
      default: begin d = '0; e = 1'b1; end
    endcase
  endfunction

  // Advance one clock, updating the model from the currently driven inputs.
  task automatic tick();
    logic [63:0] ms, mi, mt, sc, ep, ca, tv, cy, ir;
    int code;
    bit take;
    ms = m_mstatus; mi = m_mie; mt = m_mtvec; sc = m_mscratch; ep = m_mepc;
    ca = m_mcause; tv = m_mtval; cy = m_mcycle; ir = m_minstret;
    code = m_code();
    take = m_take();
    if (rst) begin
      ms = 64'ha0001800; mi = 0; mt = 0; sc = 0; ep = 0; ca = 0; tv = 0; cy = 0; ir = 0;
    end else begin
      cy = m_mcycle + 1;
      if (instret) ir = m_minstret + 1;
      if (exc_valid || take) begin
        ep = {pc[63:2], 2'b00};
        ca = exc_valid ? exc_cause : {1'b1, 63'(code)};
        tv = exc_valid ? exc_tval : 64'd0;
        ms[7] = m_mstatus[3]; ms[3] = 1'b0; ms[12:11] = 2'b11;
      end else if (mret) begin
        ms[3] = m_mstatus[7]; ms[7] = 1'b1; ms[12:11] = 2'b00;
      end else if (csr_wen && m_writable(csr_wr_addr)) begin
        case (csr_wr_addr)
          12'h300: ms = csr_wr_data;
          12'h304: mi = csr_wr_data;
          12'h305: mt = {csr_wr_data[63:2], 1'b0, csr_wr_data[0]};
          12'h340: sc = csr_wr_data;
          12'h341: ep = {csr_wr_data[63:2], 2'b00};
          12'h342: ca = csr_wr_data;
          12'h343: tv = csr_wr_data;
          12'hB00: cy = csr_wr_data;
          12'hB02: ir = csr_wr_data;
          default: ;
        endcase
      end
    end
    @(posedge clk);
    m_mstatus = ms; m_mie = mi; m_mtvec = mt; m_mscratch = sc; m_mepc = ep;
    m_mcause = ca; m_mtval = tv; m_mcycle = cy; m_minstret = ir;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    csr_wen = 0; csr_wr_addr = 0; csr_wr_data = 0; exc_valid = 0; exc_cause = 0;
    exc_tval = 0; pc = 0; boundary = 0; instret = 0; mret = 0;
    irq_mti = 0; irq_msi = 0; irq_mei = 0;
  endtask

  task automatic do_write(input logic [11:0] a, input logic [63:0] d);
    csr_wen = 1; csr_wr_addr = a; csr_wr_data = d;
    tick();
    csr_wen = 0;
  endtask

  task automatic test_reset();
    csr_rd_addr = 12'h300; #1;
    checks++; if (csr_rd_data !== 64'ha0001800) begin errors++; $display("FAIL reset_mstatus got %h exp %h", csr_rd_data, 64'ha0001800); end
    checks++; if (jmp !== 1'b0 || intr_take !== 1'b0) begin errors++; $display("FAIL reset_jmp got %b/%b exp 0/0", jmp, intr_take); end
    csr_rd_addr = 12'h305; #1;
    checks++; if (csr_rd_data !== 64'd0) begin errors++; $display("FAIL reset_mtvec got %h exp 0", csr_rd_data); end
    csr_rd_addr = 12'h7C0; #1;
    checks++; if (csr_rd_data !== 64'd0 || csr_rd_err !== 1'b1) begin errors++; $display("FAIL unmapped_read got %h/%b exp 0/1", csr_rd_data, csr_rd_err); end
    tick();
  endtask

  task automatic test_vectored_irq();
    do_write(12'h305, 64'h8000_1001);
    do_write(12'h304, 64'h80);
    do_write(12'h300, 64'ha0001808);
    irq_mti = 1; boundary = 1; pc = 64'h8000_0104; #1;
    checks++; if (intr_take !== 1'b1 || jmp !== 1'b1) begin errors++; $display("FAIL irq_take got %b/%b exp 1/1", intr_take, jmp); end
    checks++; if (nxtpc !== 64'h8000_101C) begin errors++; $display("FAIL irq_vector got %h exp %h", nxtpc, 64'h8000_101C); end
    tick();
    idle_inputs();
    csr_rd_addr = 12'h342; #1;
    checks++; if (csr_rd_data !== 64'h8000_0000_0000_0007) begin errors++; $display("FAIL irq_mcause got %h exp %h", csr_rd_data, 64'h8000_0000_0000_0007); end
    csr_rd_addr = 12'h341; #1;
    checks++; if (csr_rd_data !== 64'h8000_0104) begin errors++; $display("FAIL irq_mepc got %h exp %h", csr_rd_data, 64'h8000_0104); end
    csr_rd_addr = 12'h300; #1;
    checks++; if (csr_rd_data !== 64'ha0001880) begin errors++; $display("FAIL irq_mstatus got %h exp %h", csr_rd_data, 64'ha0001880); end
    tick();
  endtask

  task automatic test_priority();
    do_write(12'h304, 64'h888);
    do_write(12'h300, 64'ha0001808);
    irq_mti = 1; irq_msi = 1; irq_mei = 1; boundary = 1; pc = 64'h8000_0200; #1;
    checks++; if (intr_take !== 1'b1 || nxtpc !== 64'h8000_102C) begin errors++; $display("FAIL prio_mei got %b/%h exp 1/%h", intr_take, nxtpc, 64'h8000_102C); end
    exc_valid = 1; exc_cause = 64'd2; exc_tval = 64'hDEAD; #1;
    checks++; if (intr_take !== 1'b0 || jmp !== 1'b1) begin errors++; $display("FAIL exc_over_irq got %b/%b exp 0/1", intr_take, jmp); end
    checks++; if (nxtpc !== 64'h8000_1000) begin errors++; $display("FAIL exc_target got %h exp %h", nxtpc, 64'h8000_1000); end
    tick();
    idle_inputs();
    csr_rd_addr = 12'h343; #1;
    checks++; if (csr_rd_data !== 64'hDEAD) begin errors++; $display("FAIL exc_mtval got %h exp DEAD", csr_rd_data); end
    csr_rd_addr = 12'h342; #1;
    checks++; if (csr_rd_data !== 64'd2) begin errors++; $display("FAIL exc_mcause got %h exp 2", csr_rd_data); end
  endtask

  task automatic test_mret();
    mret = 1; #1;
    checks++; if (jmp !== 1'b1 || nxtpc !== 64'h8000_0200) begin errors++; $display("FAIL mret_target got %b/%h exp 1/%h", jmp, nxtpc, 64'h8000_0200); end
    tick();
    mret = 0;
    csr_rd_addr = 12'h300; #1;
    checks++; if (csr_rd_data !== 64'ha0000088) begin errors++; $display("FAIL mret_mstatus got %h exp %h", csr_rd_data, 64'ha0000088); end
    tick();
  endtask

  task automatic test_level();
    irq_mti = 1; boundary = 0; #1;
    checks++; if (intr_take !== 1'b0 || jmp !== 1'b0) begin errors++; $display("FAIL level_noboundary got %b/%b exp 0/0", intr_take, jmp); end
    tick();
    irq_mti = 0; boundary = 1; #1;
    checks++; if (intr_take !== 1'b0) begin errors++; $display("FAIL level_dropped got %b exp 0", intr_take); end
    tick();
    boundary = 0;
    csr_rd_addr = 12'h342; #1;
    checks++; if (csr_rd_data !== 64'd2) begin errors++; $display("FAIL level_mcause got %h exp 2", csr_rd_data); end
  endtask

  task automatic test_counters();
    do_write(12'hB00, 64'hFFFF_FFFF_FFFF_FFFE);
    csr_rd_addr = 12'hB00; #1;
    checks++; if (csr_rd_data !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL mcycle_written got %h exp FFFFFFFFFFFFFFFE", csr_rd_data); end
    tick(); #1;
    checks++; if (csr_rd_data !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL mcycle_ones got %h exp FFFFFFFFFFFFFFFF", csr_rd_data); end
    tick(); #1;
    checks++; if (csr_rd_data !== 64'd0) begin errors++; $display("FAIL mcycle_wrap got %h exp 0", csr_rd_data); end
    instret = 1;
    do_write(12'hB02, 64'h1234);
    instret = 0;
    csr_rd_addr = 12'hB02; #1;
    checks++; if (csr_rd_data !== 64'h1234) begin errors++; $display("FAIL minstret_write got %h exp 1234", csr_rd_data); end
    tick();
  endtask

  task automatic test_illegal();
    csr_wen = 1; csr_wr_addr = 12'h344; csr_wr_data = '1; #1;
    checks++; if (csr_wr_err !== 1'b1) begin errors++; $display("FAIL mip_wr_err got %b exp 1", csr_wr_err); end
    tick();
    csr_wr_addr = 12'hF14; #1;
    checks++; if (csr_wr_err !== 1'b1) begin errors++; $display("FAIL mhartid_wr_err got %b exp 1", csr_wr_err); end
    tick();
    csr_wen = 0;
    csr_rd_addr = 12'h344; #1;
    checks++; if (csr_rd_data !== 64'd0) begin errors++; $display("FAIL mip_unchanged got %h exp 0", csr_rd_data); end
    csr_rd_addr = 12'hF14; #1;
    checks++; if (csr_rd_data !== 64'd0) begin errors++; $display("FAIL mhartid_unchanged got %h exp 0", csr_rd_data); end
    tick();
    do_write(12'h340, 64'h55);
    csr_wen = 1; csr_wr_addr = 12'h340; csr_wr_data = 64'hAA;
    exc_valid = 1; exc_cause = 64'd5; pc = 64'h8000_0300; #1;
    checks++; if (csr_wr_err !== 1'b0 || jmp !== 1'b1) begin errors++; $display("FAIL drop_flags got %b/%b exp 0/1", csr_wr_err, jmp); end
    tick();
    idle_inputs();
    csr_rd_addr = 12'h340; #1;
    checks++; if (csr_rd_data !== 64'h55) begin errors++; $display("FAIL write_dropped got %h exp 55", csr_rd_data); end
    tick();
  endtask

  task automatic test_random();
    logic [11:0] pool [14] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
                               12'h342, 12'h343, 12'h344, 12'hB00, 12'hB02, 12'hF14,
                               12'h7C0, 12'h000};
    logic [63:0] ed;
    bit ee;
    for (int n = 0; n < 600; n++) begin
      csr_wen     = ($urandom_range(0, 2) == 0);
      csr_wr_addr = pool[$urandom_range(0, 13)];
      if (csr_wr_addr == 12'h000) csr_wr_addr = 12'($urandom);
      csr_wr_data = {$urandom, $urandom};
      exc_valid   = ($urandom_range(0, 7) == 0);
      exc_cause   = 64'($urandom_range(0, 15));
      exc_tval    = {$urandom, $urandom};
      pc          = {$urandom, $urandom};
      boundary    = 1'($urandom);
      instret     = 1'($urandom);
      mret        = ($urandom_range(0, 7) == 0);
      irq_mti     = ($urandom_range(0, 3) == 0);
      irq_msi     = ($urandom_range(0, 3) == 0);
      irq_mei     = ($urandom_range(0, 3) == 0);
      csr_rd_addr = pool[$urandom_range(0, 13)];
      if (csr_rd_addr == 12'h000) csr_rd_addr = 12'($urandom);
      #1;
      m_read(csr_rd_addr, ed, ee);
      checks++; if (csr_rd_data !== ed || csr_rd_err !== ee) begin errors++; $display("FAIL rnd_read[%0d] addr %h got %h/%b exp %h/%b", n, csr_rd_addr, csr_rd_data, csr_rd_err, ed, ee); end
      checks++; if (intr_take !== m_take()) begin errors++; $display("FAIL rnd_take[%0d] got %b exp %b", n, intr_take, m_take()); end
      checks++; if (jmp !== (exc_valid || m_take() || mret)) begin errors++; $display("FAIL rnd_jmp[%0d] got %b exp %b", n, jmp, exc_valid || m_take() || mret); end
      checks++; if (csr_wr_err !== (csr_wen && !m_writable(csr_wr_addr))) begin errors++; $display("FAIL rnd_wr_err[%0d] got %b exp %b", n, csr_wr_err, csr_wen && !m_writable(csr_wr_addr)); end
      if (jmp === 1'b1) begin
        checks++; if (nxtpc !== m_target()) begin errors++; $display("FAIL rnd_nxtpc[%0d] got %h exp %h", n, nxtpc, m_target()); end
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1; csr_rd_addr = 0;
    idle_inputs();
    @(negedge clk);
    tick();
    tick();
    rst = 0;
    test_reset();
    test_vectored_irq();
    test_priority();
    test_mret();
    test_level();
    test_counters();
    test_illegal();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_220066_csr_unit.md
Name: ysyx_220066_csr_unit

Overview:
Parametrised machine-mode CSR file and trap controller for the ysyx_220066 core. It extends the basic mepc/mstatus/mcause/mtvec set with mie/mip, mscratch, mtval, misa, mhartid and free-running mcycle/minstret counters. It adds prioritised timer/software/external interrupts and vectored mtvec. It sits beside the execute/writeback stage, supplies CSR read data, and drives jmp/nxtpc to the fetch unit on trap entry or mret.

Parameters:
XLEN, 64, data width of every CSR and PC.
HAS_COUNTERS, 1, 1 = mcycle/minstret implemented; 0 = both read 0 and are illegal to write.
VECTORED_EN, 1, 1 = honour mtvec.MODE=1 for interrupts; 0 = MODE field forced 0.
RESET_MSTATUS, 64'ha0001800, mstatus reset value.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
csr_rd_addr  in  12  read address
csr_rd_data  out  XLEN  combinational read data
csr_rd_err  out  1  read address unimplemented
csr_wen  in  1  CSR instruction write strobe
csr_wr_addr  in  12  write address
csr_wr_data  in  XLEN  write data (already merged by csrwork)
csr_wr_err  out  1  write to unimplemented or read-only CSR
exc_valid  in  1  synchronous exception this cycle
exc_cause  in  XLEN  exception code (bit XLEN-1 = 0)
exc_tval  in  XLEN  faulting address/instruction
pc  in  XLEN  PC of the current instruction
boundary  in  1  pipeline may accept an interrupt before pc
instret  in  1  one instruction retired this cycle
mret  in  1  mret executing
irq_mti, irq_msi, irq_mei  in  1 each  level interrupt lines
intr_take  out  1  interrupt taken this cycle
jmp  out  1  redirect fetch
nxtpc  out  XLEN  redirect target

Behaviour:
- Reset: mstatus=RESET_MSTATUS; mie, mtvec, mscratch, mepc, mcause, mtval, mcycle, minstret = 0. All outputs are combinational, so with inputs idle after reset: jmp=0, intr_take=0.
- Address map: 300 mstatus, 301 misa, 304 mie, 305 mtvec, 340 mscratch, 341 mepc, 342 mcause, 343 mtval, 344 mip, B00 mcycle, B02 minstret, F14 mhartid.
- Fixed values: misa = {2'b10, zeros, I and M bits}. mhartid = 0.
- mip is bit 7 = irq_mti, bit 3 = irq_msi, bit 11 = irq_mei. All other mip bits are 0.
- Unmapped read: data 0, csr_rd_err=1.
- Reads are combinational and return the pre-update value, so a same-cycle write is not visible until the next cycle.
- Write masking: mepc[1:0] forced 0; mtvec[1] forced 0 (mtvec[0] also forced 0 if VECTORED_EN=0).
- Writes to mip, misa, mhartid, any address with addr[11:10]=2'b11, or unmapped addresses: csr_wr_err=1 and no state change.
- intr_pend = mstatus.MIE & |(mip & mie).
- Interrupt selection: intr_take = boundary & intr_pend & ~exc_valid. Priority MEI(11) > MSI(3) > MTI(7). Cause = {1, code}.
- Trap entry (exc_valid or intr_take), updated at the next edge:
  - mepc <= {pc[XLEN-1:2], 2'b00}
  - mcause <= cause
  - mtval <= exc_tval for exceptions, 0 for interrupts
  - MPIE <= MIE, MIE <= 0, MPP <= 2'b11
- mret: MIE <= MPIE, MPIE <= 1, MPP <= 2'b00.
- jmp = exc_valid | intr_take | mret.
- nxtpc:
  - trap: mtvec base {mtvec[XLEN-1:2], 00}.
  - interrupt with MODE=1: base + 4*code.
  - mret: current mepc register.
- Same-cycle priority: rst > exception > interrupt > mret > CSR write. A lower-priority CSR write in that cycle is dropped with no state change, and csr_wr_err still reflects only the address check.
- Counters:
  - mcycle increments every non-reset cycle; minstret increments when instret=1.
  - Both wrap from all-ones to 0.
  - A CSR write to a counter wins over that cycle's increment; the written value appears next cycle with no +1.
- Interrupt lines are level sensitive; nothing is latched internally. If a line drops before boundary, no trap occurs.

Test Plan:
- Reset, then read 300 → A0001800; read 305 → 0; read 7C0 → data 0, csr_rd_err=1.
- Write mtvec=0x80001001 (VECTORED_EN=1), mie bit7=1, mstatus.MIE=1; irq_mti=1, boundary=1, pc=0x80000104 → intr_take=1, jmp=1, nxtpc=0x8000101C. Next cycle: mcause=0x8000_0000_0000_0007, mepc=0x80000104, MIE=0, MPIE=1, MPP=11.
- Assert irq_mei, irq_msi and irq_mti together with all enabled → cause code 11. Same cycle exc_valid=1, cause=2, tval=0xDEAD → exception taken, intr_take=0, mtval=0xDEAD, nxtpc=base.
- After trap, mret=1 → nxtpc=mepc, jmp=1. Next cycle: MIE=1, MPIE=1, MPP=00.
- Write mcycle=FFFF…FFFE, then idle 2 cycles → reads FFFF…FFFF then 0. A minstret write with instret=1 in the same cycle → written value, no +1.
- Write mip or mhartid → csr_wr_err=1, value unchanged. csr_wen together with exc_valid → write dropped.
